// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
// Multi-channel PWM generator. One shared period counter drives CH compare
// channels. Period, mode and duties are double-buffered: writes land in
// pending registers, and the active copies are refreshed only when the
// counter returns to 0. While the block is disabled, the active copies are
// refreshed on every clock.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       1 = run; 0 = counter held at 0, outputs low
//   period_we    write strobe for pending period/mode
//   period_in    pending period value P
//   mode_in      pending mode: 0 = edge-aligned, 1 = center-aligned
//   duty_we      write strobe for one channel's pending duty
//   duty_ch      target channel of the duty write (>= CH is ignored)
//   duty_in      pending duty value D
//   pwm_out      registered PWM outputs, bit i = channel i
//   cycle_start  one-clock pulse on the first clock of each PWM cycle
module pwm_multi_channel #(
    parameter int CH    = 4,
    parameter int CNT_W = 10,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             period_we,
    input  logic [CNT_W-1:0] period_in,
    input  logic             mode_in,
    input  logic             duty_we,
    input  logic [CH_W-1:0]  duty_ch,
    input  logic [CNT_W-1:0] duty_in,
    output logic [CH-1:0]    pwm_out,
    output logic             cycle_start
);

    logic [CNT_W-1:0] cnt;
    logic             cnt_down;
    logic [CNT_W-1:0] pend_period;
    logic             pend_mode;
    logic [CNT_W-1:0] pend_duty [CH];
    logic [CNT_W-1:0] act_period;
    logic             act_mode;
    logic [CNT_W-1:0] act_duty  [CH];
    logic             boundary;

    // Boundary = the counter's next value is 0.
    always_comb begin
        boundary = 1'b0;
        if (act_period == '0)
            boundary = 1'b1;
        else if (!act_mode)
            boundary = (cnt == act_period);
        else if (act_period == CNT_W'(1))
            boundary = (cnt == CNT_W'(1));
        else
            boundary = cnt_down && (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_period <= '0;
            pend_mode   <= 1'b0;
            for (int i = 0; i < CH; i++) pend_duty[i] <= '0;
        end else begin
            if (period_we) begin
                pend_period <= period_in;
                pend_mode   <= mode_in;
            end
            if (duty_we && (int'(duty_ch) < CH))
                pend_duty[duty_ch] <= duty_in;
        end
    end

    // Active registers sample the pending values as they stood before this
    // edge, so a write landing on a boundary edge waits for the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            cnt_down   <= 1'b0;
            act_period <= '0;
            act_mode   <= 1'b0;
            for (int i = 0; i < CH; i++) act_duty[i] <= '0;
        end else if (!enable || boundary) begin
            cnt        <= '0;
            cnt_down   <= 1'b0;
            act_period <= pend_period;
            act_mode   <= pend_mode;
            for (int i = 0; i < CH; i++) act_duty[i] <= pend_duty[i];
        end else if (act_mode && (cnt_down || cnt == act_period)) begin
            cnt      <= cnt - CNT_W'(1);
            cnt_down <= 1'b1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out     <= '0;
            cycle_start <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++)
                pwm_out[i] <= enable && (cnt < act_duty[i]);
            cycle_start <= enable && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
module tb_pwm_multi_channel;
    localparam int CH    = 3;
    localparam int CNT_W = 10;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             period_we;
    logic [CNT_W-1:0] period_in;
    logic             mode_in;
    logic             duty_we;
    logic [CH_W-1:0]  duty_ch;
    logic [CNT_W-1:0] duty_in;
    logic [CH-1:0]    pwm_out;
    logic             cycle_start;

    int checks = 0;
    int errors = 0;

    // Reference model: position k within the current PWM cycle.
    int m_pp, m_pm, m_ap, m_am, m_k;
    int m_pd [CH];
    int m_ad [CH];
    logic [CH-1:0] m_pwm;
    logic          m_cs;

    always #5 clk = ~clk;

    pwm_multi_channel #(.CH(CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .period_we(period_we), .period_in(period_in), .mode_in(mode_in),
        .duty_we(duty_we), .duty_ch(duty_ch), .duty_in(duty_in),
        .pwm_out(pwm_out), .cycle_start(cycle_start)
    );

    function automatic int cyc_len(int p, int m);
        if (p == 0) return 1;
        return m ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_at(int k, int p, int m);
        if (m != 0 && k > p) return 2 * p - k;
        return k;
    endfunction

    task automatic tick();
        int c;
        @(posedge clk);
        if (reset) begin
            m_pp = 0; m_pm = 0; m_ap = 0; m_am = 0; m_k = 0;
            for (int i = 0; i < CH; i++) begin m_pd[i] = 0; m_ad[i] = 0; end
            m_pwm = '0; m_cs = 1'b0;
        end else begin
            c = cnt_at(m_k, m_ap, m_am);
            for (int i = 0; i < CH; i++) m_pwm[i] = enable && (c < m_ad[i]);
            m_cs = enable && (c == 0);
            if (!enable || m_k == cyc_len(m_ap, m_am) - 1) begin
                m_k = 0; m_ap = m_pp; m_am = m_pm;
                for (int i = 0; i < CH; i++) m_ad[i] = m_pd[i];
            end else begin
                m_k++;
            end
            if (period_we) begin m_pp = int'(period_in); m_pm = int'(mode_in); end
            if (duty_we && int'(duty_ch) < CH) m_pd[duty_ch] = int'(duty_in);
        end
        #1;
        period_we = 1'b0;
        duty_we   = 1'b0;
    endtask

    task automatic set_period(int p, int m);
        period_we = 1'b1; period_in = CNT_W'(p); mode_in = m[0];
        tick();
    endtask

    task automatic set_duty(int ch, int d);
        duty_we = 1'b1; duty_ch = CH_W'(ch); duty_in = CNT_W'(d);
        tick();
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (pwm_out !== '0 || cycle_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_state pwm_out=%b cycle_start=%b expected 0 0", pwm_out, cycle_start);
            end
        end
        reset = 1'b0;
        enable = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL reset_idle t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
        end
    endtask

    task automatic test_edge_basic();
        int cs_cnt, hi0, hi1, hi2, bad_rise;
        logic prev0;
        enable = 1'b0;
        set_period(9, 0); set_duty(0, 3); set_duty(1, 0); set_duty(2, 10); tick();
        enable = 1'b1;
        cs_cnt = 0; hi0 = 0; hi1 = 0; hi2 = 0; bad_rise = 0; prev0 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL edge_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            if (n == 0) begin
                checks++;
                if (cycle_start !== 1'b1) begin
                    errors++;
                    $display("FAIL edge_first_cs cycle_start=%b expected 1", cycle_start);
                end
            end
            if (cycle_start === 1'b1) begin
                cs_cnt++;
                if (!(pwm_out[0] === 1'b1 && prev0 === 1'b0)) bad_rise++;
            end
            hi0 += int'(pwm_out[0] === 1'b1);
            hi1 += int'(pwm_out[1] === 1'b1);
            hi2 += int'(pwm_out[2] === 1'b1);
            prev0 = pwm_out[0];
        end
        checks++;
        if (cs_cnt != 4 || hi0 != 12 || hi1 != 0 || hi2 != 40 || bad_rise != 0) begin
            errors++;
            $display("FAIL edge_counts cs=%0d hi0=%0d hi1=%0d hi2=%0d badrise=%0d expected 4 12 0 40 0",
                     cs_cnt, hi0, hi1, hi2, bad_rise);
        end
    endtask

    task automatic test_center_basic();
        int cs_cnt, hi0, pos, bad_pos;
        enable = 1'b0;
        set_period(4, 1); set_duty(0, 2); tick();
        enable = 1'b1;
        cs_cnt = 0; hi0 = 0; pos = 0; bad_pos = 0;
        for (int n = 0; n < 32; n++) begin
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL center_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            if (cycle_start === 1'b1) begin cs_cnt++; pos = 0; end
            else pos++;
            // counter 0,1,2,3,4,3,2,1 with D=2: high at positions 0,1,7
            if (pwm_out[0] !== ((pos == 0 || pos == 1 || pos == 7) ? 1'b1 : 1'b0)) bad_pos++;
            hi0 += int'(pwm_out[0] === 1'b1);
        end
        checks++;
        if (cs_cnt != 4 || hi0 != 12 || bad_pos != 0) begin
            errors++;
            $display("FAIL center_counts cs=%0d hi0=%0d badpos=%0d expected 4 12 0", cs_cnt, hi0, bad_pos);
        end
    endtask

    task automatic test_shadow();
        int hi [8];
        int cyc, n;
        bit w1, w2;
        enable = 1'b0;
        set_period(9, 0); set_duty(0, 3); tick();
        enable = 1'b1;
        cyc = 0; n = 0; w1 = 0; w2 = 0;
        for (int i = 0; i < 8; i++) hi[i] = 0;
        while (cyc < 5 && n < 80) begin
            if (!w1 && cyc == 1 && m_k == 5) begin
                duty_we = 1'b1; duty_ch = 0; duty_in = 6; w1 = 1;
            end else if (!w2 && cyc == 2 && m_k == 9) begin
                duty_we = 1'b1; duty_ch = 0; duty_in = 2; w2 = 1;
            end
            tick(); n++;
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL shadow_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            if (cycle_start === 1'b1) cyc++;
            if (cyc < 8) hi[cyc] += int'(pwm_out[0] === 1'b1);
        end
        checks++;
        if (cyc != 5 || hi[1] != 3 || hi[2] != 6 || hi[3] != 6 || hi[4] != 2) begin
            errors++;
            $display("FAIL shadow_counts cycles=%0d hi=%0d,%0d,%0d,%0d expected 5 3,6,6,2",
                     cyc, hi[1], hi[2], hi[3], hi[4]);
        end
    endtask

    task automatic test_mode_switch();
        int len [8];
        int hi  [8];
        int cyc, n;
        bit w;
        enable = 1'b0;
        set_period(9, 0); set_duty(0, 3); tick();
        enable = 1'b1;
        cyc = 0; n = 0; w = 0;
        for (int i = 0; i < 8; i++) begin len[i] = 0; hi[i] = 0; end
        while (cyc < 4 && n < 80) begin
            if (!w && cyc == 1 && m_k == 2) begin
                period_we = 1'b1; period_in = 4; mode_in = 1'b1; w = 1;
            end
            tick(); n++;
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL switch_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            if (cycle_start === 1'b1) cyc++;
            if (cyc < 8) begin
                len[cyc]++;
                hi[cyc] += int'(pwm_out[0] === 1'b1);
            end
        end
        checks++;
        if (cyc != 4 || len[1] != 10 || len[2] != 8 || len[3] != 8 || hi[2] != 5) begin
            errors++;
            $display("FAIL switch_lengths cycles=%0d len=%0d,%0d,%0d hi2=%0d expected 4 10,8,8 5",
                     cyc, len[1], len[2], len[3], hi[2]);
        end
    endtask

    task automatic test_edge_cases();
        int cs_cnt, hi0, other_hi, alt_bad;
        enable = 1'b0;
        set_period(0, 0); set_duty(0, 1); set_duty(1, 0); set_duty(2, 0); tick();
        enable = 1'b1;
        cs_cnt = 0; hi0 = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL p0_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            cs_cnt += int'(cycle_start === 1'b1);
            hi0    += int'(pwm_out[0] === 1'b1);
        end
        checks++;
        if (cs_cnt != 10 || hi0 != 10) begin
            errors++;
            $display("FAIL p0_counts cs=%0d hi0=%0d expected 10 10", cs_cnt, hi0);
        end

        enable = 1'b0;
        set_period(1, 1); tick();
        enable = 1'b1;
        cs_cnt = 0; hi0 = 0; alt_bad = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL p1c_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            cs_cnt += int'(cycle_start === 1'b1);
            hi0    += int'(pwm_out[0] === 1'b1);
            if (pwm_out[0] !== ((n % 2 == 0) ? 1'b1 : 1'b0)) alt_bad++;
        end
        checks++;
        if (cs_cnt != 10 || hi0 != 10 || alt_bad != 0) begin
            errors++;
            $display("FAIL p1c_counts cs=%0d hi0=%0d altbad=%0d expected 10 10 0", cs_cnt, hi0, alt_bad);
        end

        duty_we = 1'b1; duty_ch = 2'd3; duty_in = 7;
        other_hi = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL badch_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            other_hi += int'(pwm_out[1] === 1'b1) + int'(pwm_out[2] === 1'b1);
        end
        checks++;
        if (other_hi != 0) begin
            errors++;
            $display("FAIL badch_ignored high_count=%0d expected 0", other_hi);
        end
    endtask

    task automatic test_enable_reset();
        int n, hi0, cs_cnt;
        enable = 1'b0;
        set_period(9, 0); set_duty(0, 5); tick();
        enable = 1'b1;
        n = 0;
        tick();
        while (m_k != 4 && n < 30) begin tick(); n++; end
        checks++;
        if (pwm_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL en_pre_high pwm_out0=%b expected 1", pwm_out[0]);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (pwm_out !== '0 || cycle_start !== 1'b0) begin
            errors++;
            $display("FAIL en_drop pwm_out=%b cs=%b expected 0 0", pwm_out, cycle_start);
        end
        tick(); tick(); tick();
        enable = 1'b1;
        hi0 = 0; cs_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL en_model t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
            if (i == 0 || i == 10) begin
                checks++;
                if (cycle_start !== 1'b1) begin
                    errors++;
                    $display("FAIL en_cs_pos i=%0d cycle_start=%b expected 1", i, cycle_start);
                end
            end
            if (i < 10) begin
                hi0    += int'(pwm_out[0] === 1'b1);
                cs_cnt += int'(cycle_start === 1'b1);
            end
        end
        checks++;
        if (hi0 != 5 || cs_cnt != 1) begin
            errors++;
            $display("FAIL en_first_cycle hi0=%0d cs=%0d expected 5 1", hi0, cs_cnt);
        end

        n = 0;
        while (m_k != 2 && n < 30) begin tick(); n++; end
        checks++;
        if (pwm_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_high pwm_out0=%b expected 1", pwm_out[0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pwm_out !== '0 || cycle_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_async pwm_out=%b cs=%b expected 0 0", pwm_out, cycle_start);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (pwm_out !== '0 || pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL rst_after t=%0t pwm_out=%b cs=%b expected 000 %b", $time, pwm_out, cycle_start, m_cs);
            end
        end
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(99) < 3) enable = ~enable;
            if ($urandom_range(99) < 5) begin
                period_we = 1'b1;
                period_in = CNT_W'($urandom_range(12));
                mode_in   = 1'($urandom_range(1));
            end
            if ($urandom_range(99) < 20) begin
                duty_we = 1'b1;
                duty_ch = CH_W'($urandom_range(3));
                duty_in = CNT_W'($urandom_range(14));
            end
            tick();
            checks++;
            if (pwm_out !== m_pwm || cycle_start !== m_cs) begin
                errors++;
                $display("FAIL random t=%0t pwm_out=%b cs=%b expected %b %b", $time, pwm_out, cycle_start, m_pwm, m_cs);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; period_we = 1'b0; period_in = '0; mode_in = 1'b0;
        duty_we = 1'b0; duty_ch = '0; duty_in = '0;
        m_pp = 0; m_pm = 0; m_ap = 0; m_am = 0; m_k = 0;
        for (int i = 0; i < CH; i++) begin m_pd[i] = 0; m_ad[i] = 0; end
        m_pwm = '0; m_cs = 1'b0;
        #1;
        test_reset();
        test_edge_basic();
        test_center_basic();
        test_shadow();
        test_mode_switch();
        test_edge_cases();
        test_enable_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- Multi-channel PWM generator for the car's drive and steering outputs.
- Replaces the single-channel, fixed 256-step PWM divider.
- One shared period counter drives CH compare channels. Width, period and mode are programmable.
- Period, mode and duty writes are double-buffered. They take effect only at a PWM cycle boundary, so motors never see a glitched pulse.

Parameters:
CH, 4, number of PWM channels (1..16)
CNT_W, 10, counter/period/duty width in bits
CH_W, 2, channel index width; must satisfy 2**CH_W >= CH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = run; 0 = counter held at 0, all pwm_out low
period_we  in  1  write strobe for pending period/mode
period_in  in  CNT_W  pending period value P
mode_in  in  1  pending mode: 0 = edge-aligned, 1 = center-aligned
duty_we  in  1  write strobe for one channel's pending duty
duty_ch  in  CH_W  target channel of duty write
duty_in  in  CNT_W  pending duty value D
pwm_out  out  CH  registered PWM outputs, bit i = channel i
cycle_start  out  1  one-clock pulse marking the first clock of each PWM cycle

Behaviour:
- Reset (async): counter, direction flag, all pending and active registers (period, mode, duties) cleared to 0. pwm_out = 0, cycle_start = 0.
- Pending registers:
  - period_we loads pending period/mode.
  - duty_we loads pending duty[duty_ch].
  - duty_ch >= CH: write ignored.
  - period_we and duty_we in the same cycle: both take effect.
  - Repeated writes before a boundary: last one wins.
- Active registers are loaded from pending at every boundary edge, i.e. the clock edge on which the counter returns to 0.
  - Pending values written on that same edge are NOT captured; they apply at the following boundary.
  - While enable = 0, active registers load from pending every clock.
- Edge mode:
  - Counter sequence 0,1,...,P, then 0. Cycle length P+1 clocks.
  - Boundary when cnt == P.
- Center mode:
  - Counter sequence 0,1,...,P,P-1,...,1, then 0. Cycle length 2P clocks.
  - A direction flag flips at cnt == P (up to down).
  - Boundary when the next value is 0: cnt == 1 while counting down, or cnt == 1 with P == 1.
- P == 0 (either mode): counter stays 0 and every clock is a boundary.
- Mode or period change: takes effect only at a boundary. The counter restarts at 0 counting up, with the direction flag cleared.
- Compare: pwm_out[i] <= enable && (cnt < duty_act[i]). Registered, so latency is 1 clock from counter value to output.
  - Edge mode: high time = min(D, P+1) clocks per cycle.
  - D == 0: output always low.
  - D > P: output always high.
  - Center mode: high time = 2D-1 clocks for 1 <= D <= P, centred on cnt = 0; all-high for D > P.
- cycle_start: registered alongside pwm_out. High for exactly one clock, in the cycle where pwm_out reflects cnt == 0; only while enable = 1.
- Enable:
  - enable falling: counter forced to 0 and direction flag cleared on the next edge. pwm_out and cycle_start go 0 on that same edge.
  - enable rising: counter starts at 0. First cycle_start occurs 1 clock after enable is sampled high.
- Reset asserted mid-cycle: all outputs low immediately (async). After release, the block is idle with P = 0 and all duties 0 until reprogrammed.
- Arithmetic:
  - All compares are unsigned, CNT_W bits.
  - The counter never exceeds P, so no wrap-around beyond CNT_W.
  - The P+1 cycle length is a count of clocks only, never stored.

Test Plan:
- Edge basic: P = 9, mode 0, D0 = 3, D1 = 0, D2 = 10, enable -> ch0 repeats 3 high / 7 low, ch1 constant 0, ch2 constant 1. cycle_start every 10 clocks, coincident with ch0 rising.
- Center basic: P = 4, mode 1, D0 = 2 -> counter 0,1,2,3,4,3,2,1. ch0 high 3 of 8 clocks (at cnt 1,0,1), cycle_start every 8 clocks.
- Shadowing: running P = 9, D0 = 3; write D0 = 6 mid-cycle (cnt = 5) -> current cycle stays 3 high; next cycle 6 high. Write landing on boundary edge (cnt = 9) -> applied one cycle later.
- Period/mode switch: edge P = 9 -> write P = 4, mode 1 at cnt = 2 -> edge cycle completes (10 clocks), then center cycles of 8 clocks starting at cnt 0 counting up.
- Edge cases: P = 0, D = 1 -> pwm_out constant 1, cycle_start every clock. P = 1 center, D = 1 -> period 2, 1 high / 1 low. duty_ch = CH -> no channel changes.
- Enable/reset: drop enable mid-cycle -> outputs 0 next edge; re-enable -> cycle_start 1 clock later, full first cycle. Assert reset mid-high -> pwm_out 0 without a clock edge; all registers read back 0 behaviour after release.
